// File: rtl/stopwatch_timer_ctrl.sv
// stopwatch_timer_ctrl: two-button stopwatch / countdown timer controller.
// Owns mode FSM, button edge detect, tick prescaler, shared up/down counter.
// Optional lap buffer: define STOPWATCH_LAP_EN to build it.
// Ports: clk, nrst (sync, active-low), pb0/pb1 debounced button levels,
//   disp (registered display value), output_select (display mode),
//   time_up, paused, lap_view/lap_idx (stored-lap display status).
module stopwatch_timer_ctrl #(
    parameter int CNT_W     = 16,
    parameter int TICK_DIV  = 100,
    parameter int LAP_DEPTH = 4,
    parameter int STEP      = 1
) (
    input  logic                         clk,
    input  logic                         nrst,
    input  logic                         pb0,
    input  logic                         pb1,
    output logic [CNT_W-1:0]             disp,
    output logic [1:0]                   output_select,
    output logic                         time_up,
    output logic                         paused,
    output logic                         lap_view,
    output logic [$clog2(LAP_DEPTH)-1:0] lap_idx
);
    localparam int IDX_W = $clog2(LAP_DEPTH);
    localparam int PRE_W = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [2:0] {
        MODE_SELECT = 3'd0,
        CLEAR       = 3'd1,
        STOPWATCH   = 3'd2,
        LAST_TIME   = 3'd3,
        INPUT       = 3'd4,
        TIMER       = 3'd5,
        TIME_UP     = 3'd6
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    logic [CNT_W-1:0] preset;
    logic [CNT_W-1:0] preset_next;
    logic             paused_next;
    logic [PRE_W-1:0] presc;
    logic             pb0_prev;
    logic             pb1_prev;
    logic             press0;
    logic             press1;
    logic             counting;
    logic             tick;
    logic             enter_run;
    logic [CNT_W:0]   preset_sum;
    logic [CNT_W-1:0] preset_inc;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] lap_disp;
    logic [CNT_W-1:0] disp_next;

    assign press0 = pb0 & ~pb0_prev;
    assign press1 = pb1 & ~pb1_prev;

    assign counting = (state == STOPWATCH) ||
                      ((state == TIMER) && !paused);
    assign tick = counting && (presc == PRE_W'(TICK_DIV - 1));

    // Prescaler restarts whenever a counting mode is freshly entered.
    assign enter_run = (next_state != state) &&
                       ((next_state == STOPWATCH) ||
                        (next_state == TIMER));

    assign preset_sum = {1'b0, preset} + (CNT_W+1)'(STEP);
    assign preset_inc = preset_sum[CNT_W] ? CNT_MAX
                                          : preset_sum[CNT_W-1:0];
    assign cnt_inc = (count == CNT_MAX) ? count
                                        : count + CNT_W'(1);

`ifdef STOPWATCH_LAP_EN
    logic capture;
    logic view_step;
    logic leave_view;
    logic clear_laps;
`endif

    always_comb begin
        next_state  = state;
        count_next  = count;
        preset_next = preset;
        paused_next = paused;
`ifdef STOPWATCH_LAP_EN
        capture     = 1'b0;
        view_step   = 1'b0;
        leave_view  = 1'b0;
        clear_laps  = 1'b0;
`endif
        unique case (state)
            MODE_SELECT: begin
                if (press0)
                    next_state = CLEAR;
                else if (press1)
                    next_state = INPUT;
            end
            CLEAR: begin
                count_next = '0;
                next_state = STOPWATCH;
`ifdef STOPWATCH_LAP_EN
                clear_laps = 1'b1;
`endif
            end
            STOPWATCH: begin
                if (tick)
                    count_next = cnt_inc;
                if (press0)
                    next_state = LAST_TIME;
`ifdef STOPWATCH_LAP_EN
                capture = press1;
`endif
            end
            LAST_TIME: begin
                if (press0)
                    next_state = MODE_SELECT;
`ifdef STOPWATCH_LAP_EN
                leave_view = press0;
                view_step  = press1 & ~press0;
`endif
            end
            INPUT: begin
                if (press0) begin
                    preset_next = preset_inc;
                end else if (press1) begin
                    count_next = preset;
                    next_state = (preset == '0) ? TIME_UP : TIMER;
                end
            end
            TIMER: begin
                // Expiry wins over both buttons on the same edge.
                if (tick && (count <= CNT_W'(1))) begin
                    count_next = '0;
                    next_state = TIME_UP;
                end else begin
                    if (tick)
                        count_next = count - CNT_W'(1);
                    if (press1) begin
                        next_state  = MODE_SELECT;
                        paused_next = 1'b0;
                    end else if (press0) begin
                        paused_next = ~paused;
                    end
                end
            end
            TIME_UP: begin
                if (press0) begin
                    next_state  = MODE_SELECT;
                    paused_next = 1'b0;
                end
            end
            default: next_state = MODE_SELECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state    <= MODE_SELECT;
            count    <= '0;
            preset   <= '0;
            paused   <= 1'b0;
            presc    <= '0;
            pb0_prev <= 1'b1;
            pb1_prev <= 1'b1;
            disp     <= '0;
        end else begin
            state    <= next_state;
            count    <= count_next;
            preset   <= preset_next;
            paused   <= paused_next;
            pb0_prev <= pb0;
            pb1_prev <= pb1;
            disp     <= disp_next;
            if (enter_run || tick)
                presc <= '0;
            else if (counting)
                presc <= presc + PRE_W'(1);
        end
    end

`ifdef STOPWATCH_LAP_EN
    logic [CNT_W-1:0] laps [LAP_DEPTH];
    logic [IDX_W-1:0] wr_ptr;
    logic [IDX_W:0]   lap_cnt;
    logic [IDX_W-1:0] oldest;
    logic [IDX_W-1:0] newest;

    // When full, lap_cnt low bits are zero, so oldest == wr_ptr.
    assign oldest   = wr_ptr - lap_cnt[IDX_W-1:0];
    assign newest   = wr_ptr - IDX_W'(1);
    assign lap_disp = laps[lap_idx];

    always_ff @(posedge clk) begin
        if (nrst && capture)
            laps[wr_ptr] <= count;
    end

    always_ff @(posedge clk) begin
        if (!nrst || clear_laps) begin
            wr_ptr   <= '0;
            lap_cnt  <= '0;
            lap_view <= 1'b0;
            lap_idx  <= '0;
        end else begin
            if (capture) begin
                wr_ptr <= wr_ptr + IDX_W'(1);
                if (lap_cnt != (IDX_W+1)'(LAP_DEPTH))
                    lap_cnt <= lap_cnt + (IDX_W+1)'(1);
            end
            if (leave_view) begin
                lap_view <= 1'b0;
            end else if (view_step && (lap_cnt != '0)) begin
                if (!lap_view) begin
                    lap_view <= 1'b1;
                    lap_idx  <= oldest;
                end else if (lap_idx == newest) begin
                    lap_view <= 1'b0;
                end else begin
                    lap_idx <= lap_idx + IDX_W'(1);
                end
            end
        end
    end
`else
    assign lap_view = 1'b0;
    assign lap_idx  = '0;
    assign lap_disp = count;
`endif

    always_comb begin
        disp_next = count;
        unique case (state)
            MODE_SELECT, INPUT: disp_next = preset;
            LAST_TIME: disp_next = lap_view ? lap_disp : count;
            default:   disp_next = count;
        endcase
    end

    always_comb begin
        output_select = 2'b00;
        unique case (state)
            CLEAR, STOPWATCH, LAST_TIME: output_select = 2'b01;
            INPUT, TIMER:                output_select = 2'b10;
            TIME_UP:                     output_select = 2'b11;
            default:                     output_select = 2'b00;
        endcase
    end

    assign time_up = (state == TIME_UP);

endmodule

// File: tb/tb_stopwatch_timer_ctrl.sv
// Bench for stopwatch_timer_ctrl: directed scenarios then random buttons,
// checked every cycle against an arithmetic reference model.
module tb_stopwatch_timer_ctrl;
    localparam int CNT_W     = 8;
    localparam int TICK_DIV  = 4;
    localparam int LAP_DEPTH = 2;
    localparam int STEP      = 1;
    localparam int IDX_W     = $clog2(LAP_DEPTH);
    localparam int MAXV      = (1 << CNT_W) - 1;

    typedef enum {SEL, CLR, RUN_UP, FROZEN, ENTRY, RUN_DOWN, EXPIRED} mode_t;

    logic             clk = 1'b0;
    logic             nrst = 1'b0;
    logic             pb0 = 1'b1;
    logic             pb1 = 1'b0;
    logic [CNT_W-1:0] disp;
    logic [1:0]       output_select;
    logic             time_up;
    logic             paused;
    logic             lap_view;
    logic [IDX_W-1:0] lap_idx;

    stopwatch_timer_ctrl #(
        .CNT_W(CNT_W), .TICK_DIV(TICK_DIV),
        .LAP_DEPTH(LAP_DEPTH), .STEP(STEP)
    ) dut (
        .clk(clk), .nrst(nrst), .pb0(pb0), .pb1(pb1),
        .disp(disp), .output_select(output_select),
        .time_up(time_up), .paused(paused),
        .lap_view(lap_view), .lap_idx(lap_idx)
    );

    always #5 clk = ~clk;

    // Reference model: counts are derived from elapsed active cycles.
    mode_t m_mode   = SEL;
    int    m_cnt    = 0;
    int    m_preset = 0;
    int    m_base   = 0;
    int    m_run    = 0;
    bit    m_paused = 1'b0;
    int    laps[$];
    int    caps     = 0;
    int    vpos     = -1;
    int    e_disp   = 0;
    bit    prev0    = 1'b1;
    bit    prev1    = 1'b1;

    int vectors     = 0;
    int miscompares = 0;

    function automatic int shown();
        if (m_mode == SEL || m_mode == ENTRY) return m_preset;
        if (m_mode == FROZEN && vpos >= 0) return laps[vpos];
        return m_cnt;
    endfunction

    function automatic int want_sel();
        case (m_mode)
            CLR, RUN_UP, FROZEN: return 1;
            ENTRY, RUN_DOWN:     return 2;
            EXPIRED:             return 3;
            default:             return 0;
        endcase
    endfunction

    task automatic model_edge();
        bit p0;
        bit p1;
        int old;
        int left;
        if (!nrst) begin
            m_mode = SEL; m_cnt = 0; m_preset = 0; m_base = 0;
            m_run = 0; m_paused = 1'b0; laps.delete(); caps = 0;
            vpos = -1; e_disp = 0; prev0 = 1'b1; prev1 = 1'b1;
            return;
        end
        p0 = pb0 && !prev0;
        p1 = pb1 && !prev1;
        prev0 = pb0;
        prev1 = pb1;
        e_disp = shown();
        case (m_mode)
            SEL: begin
                if (p0) m_mode = CLR;
                else if (p1) m_mode = ENTRY;
            end
            CLR: begin
                m_cnt = 0; laps.delete(); caps = 0; vpos = -1;
                m_run = 0; m_mode = RUN_UP;
            end
            RUN_UP: begin
                old = m_cnt;
                m_run++;
                m_cnt = (m_run / TICK_DIV > MAXV) ? MAXV : m_run / TICK_DIV;
`ifdef STOPWATCH_LAP_EN
                if (p1) begin
                    laps.push_back(old);
                    caps++;
                    if (laps.size() > LAP_DEPTH) void'(laps.pop_front());
                end
`endif
                if (p0) m_mode = FROZEN;
            end
            FROZEN: begin
                if (p0) begin
                    m_mode = SEL;
                    vpos = -1;
                end
`ifdef STOPWATCH_LAP_EN
                else if (p1 && laps.size() > 0) begin
                    if (vpos < 0) vpos = 0;
                    else if (vpos == laps.size() - 1) vpos = -1;
                    else vpos++;
                end
`endif
            end
            ENTRY: begin
                if (p0) begin
                    m_preset = (m_preset + STEP > MAXV) ? MAXV : m_preset + STEP;
                end else if (p1) begin
                    m_cnt = m_preset;
                    if (m_preset == 0) m_mode = EXPIRED;
                    else begin
                        m_mode = RUN_DOWN; m_base = m_preset; m_run = 0;
                    end
                end
            end
            RUN_DOWN: begin
                if (!m_paused) m_run++;
                left = m_base - m_run / TICK_DIV;
                if (left <= 0) begin
                    m_cnt = 0;
                    m_mode = EXPIRED;
                end else begin
                    m_cnt = left;
                    if (p1) begin
                        m_mode = SEL;
                        m_paused = 1'b0;
                    end else if (p0) begin
                        m_paused = !m_paused;
                    end
                end
            end
            EXPIRED: begin
                if (p0) begin
                    m_mode = SEL;
                    m_paused = 1'b0;
                end
            end
            default: m_mode = SEL;
        endcase
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] want);
        vectors++;
        assert (obs === want) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h at %0t",
                   tag, obs, want, $time);
        end
    endtask

    task automatic check_all();
        check("disp", disp, e_disp);
        check("output_select", output_select, want_sel());
        check("time_up", time_up, m_mode == EXPIRED);
        check("paused", paused, m_paused);
`ifdef STOPWATCH_LAP_EN
        check("lap_view", lap_view, vpos >= 0);
        if (vpos >= 0)
            check("lap_idx", lap_idx, (caps - laps.size() + vpos) % LAP_DEPTH);
`else
        check("lap_view", lap_view, 0);
        check("lap_idx", lap_idx, 0);
`endif
    endtask

    task automatic cyc(input logic b0, input logic b1);
        pb0 = b0;
        pb1 = b1;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0);
    endtask

    task automatic push0();
        cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b0);
    endtask

    task automatic push1();
        cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b0);
    endtask

    initial begin
        // Reset with pb0 held; holding it afterwards must not count.
        nrst = 1'b0;
        cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b0);
        nrst = 1'b1;
        for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0);
        check("held_disp", disp, 0);
        check("held_sel", output_select, 0);

        // Stopwatch run of 40 cycles, frozen at 10.
        cyc(1'b0, 1'b0);
        cyc(1'b1, 1'b0);
        check("clear_sel", output_select, 1);
        cyc(1'b0, 1'b0);
        idle(39);
        cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b0);
        check("frozen_disp", disp, 10);
        check("frozen_sel", output_select, 1);

        // Laps at 3, 5, 7; stop at 9; browse.
        push0();
        cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b0);
        idle(12);
        cyc(1'b0, 1'b1);
        idle(7);
        cyc(1'b0, 1'b1);
        idle(7);
        cyc(1'b0, 1'b1);
        idle(6);
        cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b0);
        check("stop9_disp", disp, 9);
        push1();
`ifdef STOPWATCH_LAP_EN
        check("lap1_disp", disp, 5);
        check("lap1_view", lap_view, 1);
        check("lap1_idx", lap_idx, 1);
        push1();
        check("lap2_disp", disp, 7);
        check("lap2_idx", lap_idx, 0);
        push1();
        check("lap3_disp", disp, 9);
        check("lap3_view", lap_view, 0);
        push1();
        check("lap4_disp", disp, 5);
`else
        check("nolap_disp", disp, 9);
        check("nolap_view", lap_view, 0);
        push1();
        push1();
        check("nolap_disp2", disp, 9);
`endif

        // Timer from preset 3 expires after exactly 12 cycles.
        push0();
        push1();
        push0();
        push0();
        push0();
        check("preset3", disp, 3);
        cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b0);
        check("timer_start", disp, 3);
        idle(10);
        check("timer_r11", time_up, 0);
        check("timer_r11_disp", disp, 1);
        cyc(1'b0, 1'b0);
        check("timer_r12", time_up, 1);
        check("timeup_sel", output_select, 3);
        push0();
        check("preset_kept", disp, 3);

        // Preset 0 goes straight to time-up.
        nrst = 1'b0;
        cyc(1'b0, 1'b0);
        nrst = 1'b1;
        cyc(1'b0, 1'b0);
        push1();
        cyc(1'b0, 1'b1);
        check("zero_preset", time_up, 1);
        cyc(1'b0, 1'b0);

        // Pause at 5, resume, expire.
        push0();
        push1();
        for (int i = 0; i < 5; i++) push0();
        cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b0);
        cyc(1'b1, 1'b0);
        idle(20);
        check("pause_disp", disp, 5);
        check("pause_flag", paused, 1);
        cyc(1'b1, 1'b0);
        idle(20);
        check("resume_up", time_up, 1);
        check("resume_disp", disp, 0);
        check("resume_pause", paused, 0);
        push0();

        // Saturation of stopwatch count and preset.
        push0();
        idle(1030);
        check("sw_sat", disp, MAXV);
        push0();
        push0();
        push1();
        for (int i = 0; i < 260; i++) push0();
        check("preset_sat", disp, MAXV);
        push1();
        idle(3);
        push1();

        // Random button activity with occasional reset.
        for (int i = 0; i < 4000; i++) begin
            nrst = ($urandom_range(0, 599) != 0);
            cyc($urandom_range(0, 9) == 0, $urandom_range(0, 11) == 0);
        end
        nrst = 1'b1;
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule
